// File: rtl/nor_truth_table_checker_pkg.sv
// Shared types and helpers for the NOR truth-table checker.
//   state_t      : sweep FSM states
//   expected_nor : reference NOR of a zero-extended input vector
package nor_truth_table_checker_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Widest vector the helper accepts; callers zero-extend narrower vectors,
    // which leaves the NOR result unchanged.
    localparam int VEC_MAX = 32;

    function automatic logic expected_nor(input logic [VEC_MAX-1:0] vec);
        return ~(|vec);
    endfunction

endpackage

// File: rtl/nor_truth_table_checker_settle_counter.sv
// Settle counter: counts the cycles a vector has been held.
//   clk, reset : clock, async active-high reset
//   clear      : synchronous clear to 0 (wins over en)
//   en         : increment this cycle
//   tc         : count has reached SETTLE_CYCLES-1
module settle_counter #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tc
);
    localparam int W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(SETTLE_CYCLES - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/nor_truth_table_checker.sv
// Self-test sweep for an N-input NOR gate. On start, applies every input
// vector, holds it SETTLE_CYCLES cycles, samples the gate output for one
// cycle and compares against ~(|drive_vec).
//   clk, reset       : clock, async active-high reset
//   start            : begin a sweep (honoured in IDLE or DONE only)
//   s_in             : gate-under-test output
//   drive_vec        : vector applied to the gate
//   busy / done      : sweep in progress / sweep finished
//   pass             : no mismatches in last sweep (valid with done)
//   err_count        : mismatching vectors in last sweep
//   first_fail_vec   : first mismatching vector
//   first_fail_valid : first_fail_vec holds a captured vector
module nor_truth_table_checker
    import nor_truth_table_checker_pkg::*;
#(
    parameter int N_INPUTS      = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                s_in,
    output logic [N_INPUTS-1:0] drive_vec,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [N_INPUTS:0]   err_count,
    output logic [N_INPUTS-1:0] first_fail_vec,
    output logic                first_fail_valid
);
    state_t state, state_next;
    logic   cnt_clear, cnt_en, cnt_tc;
    logic   mismatch, last_vec;
    logic   [VEC_MAX-1:0] drive_ext;
    logic   [N_INPUTS:0]  err_next;

    settle_counter #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_settle (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .en    (cnt_en),
        .tc    (cnt_tc)
    );

    assign drive_ext = {{(VEC_MAX-N_INPUTS){1'b0}}, drive_vec};
    assign mismatch  = (s_in != expected_nor(drive_ext));
    assign last_vec  = &drive_vec;
    // Include the current sample so the final vector's result reaches pass.
    assign err_next  = err_count + {{N_INPUTS{1'b0}}, mismatch};

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        cnt_clear  = 1'b0;
        cnt_en     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = SETTLE;
                    cnt_clear  = 1'b1;
                end
            end
            SETTLE: begin
                cnt_en = 1'b1;
                if (cnt_tc)
                    state_next = SAMPLE;
            end
            SAMPLE: begin
                if (last_vec) begin
                    state_next = DONE;
                end else begin
                    state_next = SETTLE;
                    cnt_clear  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drive_vec        <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        drive_vec        <= '0;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        pass             <= 1'b0;
                        err_count        <= '0;
                        first_fail_vec   <= '0;
                        first_fail_valid <= 1'b0;
                    end
                end
                SAMPLE: begin
                    err_count <= err_next;
                    if (mismatch && !first_fail_valid) begin
                        first_fail_vec   <= drive_vec;
                        first_fail_valid <= 1'b1;
                    end
                    if (last_vec) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= (err_next == '0);
                    end else begin
                        drive_vec <= drive_vec + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
